score_readout: RTL and testbench



---
 rtl/score_readout_if.sv | 36 +++
 rtl/score_readout.sv | 180 ++++++++++++++++++
 tb/tb_score_readout.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/score_readout_if.sv
// Bus between the score readout block and its surroundings (game controls,
// register file read port, display).
//   master: drives start/next and the register file read data, observes results.
//   slave : the score_readout block itself.
//   start/next    : compute request (level) and display-advance pulse
//   registerData  : combinational read data for ReadAddress
//   ReadAddress   : register file read address
//   Busy/Valid/Empty, BestScore, AverageScore, DisplayValue, DisplayIndex : results
interface score_readout_if #(
  parameter int unsigned WIDTH      = 13,
  parameter int unsigned ADDR_WIDTH = 3
);
  logic                  start;
  logic                  next;
  logic [WIDTH-1:0]      registerData;
  logic [ADDR_WIDTH-1:0] ReadAddress;
  logic                  Busy;
  logic                  Valid;
  logic                  Empty;
  logic [WIDTH-1:0]      BestScore;
  logic [WIDTH-1:0]      AverageScore;
  logic [WIDTH-1:0]      DisplayValue;
  logic [ADDR_WIDTH-1:0] DisplayIndex;

  modport master (
    output start, next, registerData,
    input  ReadAddress, Busy, Valid, Empty, BestScore, AverageScore, DisplayValue,
           DisplayIndex
  );

  modport slave (
    input  start, next, registerData,
    output ReadAddress, Busy, Valid, Empty, BestScore, AverageScore, DisplayValue,
           DisplayIndex
  );
endinterface

// File: rtl/score_readout.sv
// Score readout: reads the trial count (register 0) and the scores (registers
// 1..count) through a single read port, computes the minimum and the truncated
// average (restoring shift-subtract divider), then lets the player step through
// the individual scores.
// Ports:
//   Clock : system clock, rising edge
//   Reset : synchronous, active-high
//   bus   : score_readout_if.slave (start/next in, register file port, results out)
module score_readout #(
  parameter int unsigned WIDTH      = 13,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned MAX_SCORES = 4
) (
  input logic            Clock,
  input logic            Reset,
  score_readout_if.slave bus
);

  // Sum of up to MAX_SCORES words; two extra bits cover MAX_SCORES = 4.
  localparam int unsigned SumW = WIDTH + 2;
  // Shifted remainder is below 2*count, so one bit above the count width.
  localparam int unsigned RemW = ADDR_WIDTH + 1;
  localparam int unsigned DivCntW = $clog2(SumW);
  localparam logic [DivCntW-1:0]    DivLast    = DivCntW'(SumW - 1);
  localparam logic [WIDTH-1:0]      MaxScoresW = WIDTH'(MAX_SCORES);
  localparam logic [ADDR_WIDTH-1:0] MaxScoresA = ADDR_WIDTH'(MAX_SCORES);

  typedef enum logic [2:0] {
    StIdle,
    StReadCount,
    StAccum,
    StDivide,
    StShow
  } state_t;

  state_t                stateQ, stateD;
  logic [ADDR_WIDTH-1:0] countQ, countD;
  logic [ADDR_WIDTH-1:0] idxQ, idxD;
  logic [SumW-1:0]       sumQ, sumD;
  logic [WIDTH-1:0]      bestQ, bestD;       // running minimum during ACCUM
  logic [SumW-1:0]       quotQ, quotD;       // dividend shifts out, quotient shifts in
  logic [ADDR_WIDTH-1:0] remQ, remD;
  logic [DivCntW-1:0]    divCntQ, divCntD;
  logic [WIDTH-1:0]      bestScoreQ, bestScoreD;
  logic [WIDTH-1:0]      avgQ, avgD;
  logic [ADDR_WIDTH-1:0] dispIdxQ, dispIdxD;

  // Divider step: one dividend bit into the remainder, conditional subtract.
  logic [RemW-1:0]       remShift;
  logic                  remGe;
  logic [ADDR_WIDTH-1:0] remNext;
  logic [SumW-1:0]       quotNext;
  logic [ADDR_WIDTH-1:0] countClamped;

  always_comb begin
    remShift = {remQ, quotQ[SumW-1]};
    remGe    = remShift >= {1'b0, countQ};
    remNext  = remGe ? ADDR_WIDTH'(remShift - {1'b0, countQ}) : ADDR_WIDTH'(remShift);
    quotNext = {quotQ[SumW-2:0], remGe};
  end

  // Full-width compare so e.g. 8 is not mistaken for 0 by its low bits.
  always_comb begin
    countClamped = (bus.registerData > MaxScoresW) ? MaxScoresA
                                                   : bus.registerData[ADDR_WIDTH-1:0];
  end

  always_comb begin
    stateD     = stateQ;
    countD     = countQ;
    idxD       = idxQ;
    sumD       = sumQ;
    bestD      = bestQ;
    quotD      = quotQ;
    remD       = remQ;
    divCntD    = divCntQ;
    bestScoreD = bestScoreQ;
    avgD       = avgQ;
    dispIdxD   = dispIdxQ;

    bus.ReadAddress  = '0;
    bus.DisplayValue = '0;

    unique case (stateQ)
      StIdle: begin
        if (bus.start) stateD = StReadCount;
      end

      StReadCount: begin
        countD = countClamped;
        if (countClamped == '0) begin
          stateD     = StShow;
          bestScoreD = '0;
          avgD       = '0;
          dispIdxD   = '0;
        end else begin
          stateD = StAccum;
          idxD   = ADDR_WIDTH'(1);
          sumD   = '0;
          bestD  = '1;
        end
      end

      StAccum: begin
        bus.ReadAddress = idxQ;
        sumD = sumQ + SumW'(bus.registerData);
        if (bus.registerData < bestQ) bestD = bus.registerData;
        idxD = idxQ + ADDR_WIDTH'(1);
        if (idxQ == countQ) begin
          stateD  = StDivide;
          quotD   = sumQ + SumW'(bus.registerData);
          remD    = '0;
          divCntD = '0;
        end
      end

      StDivide: begin
        quotD   = quotNext;
        remD    = remNext;
        divCntD = divCntQ + DivCntW'(1);
        if (divCntQ == DivLast) begin
          stateD     = StShow;
          avgD       = quotNext[WIDTH-1:0];
          bestScoreD = bestQ;
          dispIdxD   = ADDR_WIDTH'(1);
        end
      end

      StShow: begin
        bus.ReadAddress  = dispIdxQ;
        bus.DisplayValue = bus.registerData;
        if (bus.start) begin
          stateD = StReadCount;
        end else if (bus.next && (countQ != '0)) begin
          dispIdxD = (dispIdxQ == countQ) ? ADDR_WIDTH'(1) : dispIdxQ + ADDR_WIDTH'(1);
        end
      end

      default: stateD = StIdle;
    endcase
  end

  always_comb begin
    bus.Busy         = (stateQ == StReadCount) || (stateQ == StAccum) || (stateQ == StDivide);
    bus.Valid        = (stateQ == StShow);
    bus.Empty        = (stateQ == StShow) && (countQ == '0);
    bus.BestScore    = bestScoreQ;
    bus.AverageScore = avgQ;
    bus.DisplayIndex = dispIdxQ;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stateQ     <= StIdle;
      countQ     <= '0;
      idxQ       <= '0;
      sumQ       <= '0;
      bestQ      <= '0;
      quotQ      <= '0;
      remQ       <= '0;
      divCntQ    <= '0;
      bestScoreQ <= '0;
      avgQ       <= '0;
      dispIdxQ   <= '0;
    end else begin
      stateQ     <= stateD;
      countQ     <= countD;
      idxQ       <= idxD;
      sumQ       <= sumD;
      bestQ      <= bestD;
      quotQ      <= quotD;
      remQ       <= remD;
      divCntQ    <= divCntD;
      bestScoreQ <= bestScoreD;
      avgQ       <= avgD;
      dispIdxQ   <= dispIdxD;
    end
  end

endmodule

// File: tb/tb_score_readout.sv
// Self-checking bench for score_readout: table of known cases, randomized runs
// against an arithmetic reference model, and hand sequences for display
// stepping, start/next priority, empty handling and reset mid-divide.
module tb_score_readout;
  localparam int unsigned WIDTH      = 13;
  localparam int unsigned ADDR_WIDTH = 3;
  localparam int unsigned MAX_SCORES = 4;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  score_readout_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  logic [WIDTH-1:0] regs [0:7];
  assign bus.registerData = regs[bus.ReadAddress];

  score_readout #(
    .WIDTH     (WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .MAX_SCORES(MAX_SCORES)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0][WIDTH-1:0] r;
    int cnt;
    int best;
    int avg;
    int lat;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int lastBest = 0, lastAvg = 0, lastIdx = 0, lastCnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input int r0, input int a, input int b, input int c,
                                 input int d, input int e, input int cnt, input int best,
                                 input int avg, input int lat);
    vec_t v;
    v.r[0] = WIDTH'(r0); v.r[1] = WIDTH'(a); v.r[2] = WIDTH'(b); v.r[3] = WIDTH'(c);
    v.r[4] = WIDTH'(d);  v.r[5] = WIDTH'(e); v.r[6] = WIDTH'(e); v.r[7] = WIDTH'(e);
    v.cnt = cnt; v.best = best; v.avg = avg; v.lat = lat;
    return v;
  endfunction

  // Reference: clamp the count, then min and integer mean over the stored scores.
  function automatic void model(output int cnt, output int best, output int avg);
    int sum;
    cnt  = (regs[0] > WIDTH'(MAX_SCORES)) ? int'(MAX_SCORES) : int'(regs[0]);
    best = 0;
    avg  = 0;
    if (cnt > 0) begin
      sum  = 0;
      best = 8191;
      for (int i = 1; i <= cnt; i++) begin
        sum += int'(regs[i]);
        if (int'(regs[i]) < best) best = int'(regs[i]);
      end
      avg = sum / cnt;
    end
  endfunction

  task automatic runCompute(input string tag, input int expCnt, input int expBest,
                            input int expAvg, input int expLat, input bit withNext);
    int k, busyN, maxAddr;
    bit done;
    @(negedge Clock);
    bus.start = 1'b1;
    bus.next  = withNext;
    @(negedge Clock);
    bus.start = 1'b0;
    bus.next  = 1'b0;
    check({tag, " hold best"}, 32'(bus.BestScore), lastBest);
    check({tag, " hold avg"}, 32'(bus.AverageScore), lastAvg);
    check({tag, " hold idx"}, 32'(bus.DisplayIndex), lastIdx);
    k = 0; busyN = 0; maxAddr = 0; done = 1'b0;
    while (!done && k < 100) begin
      if (bus.Valid) begin
        done = 1'b1;
      end else begin
        if (bus.Busy) busyN++;
        if (int'(bus.ReadAddress) > maxAddr) maxAddr = int'(bus.ReadAddress);
        @(negedge Clock);
        k++;
      end
    end
    check({tag, " valid reached"}, 32'(done), 1);
    lastBest = expBest; lastAvg = expAvg; lastCnt = expCnt;
    lastIdx  = (expCnt != 0) ? 1 : 0;
    check({tag, " latency"}, k, expLat);
    check({tag, " busy cycles"}, busyN, expLat);
    check({tag, " max address"}, maxAddr, expCnt);
    check({tag, " best"}, 32'(bus.BestScore), expBest);
    check({tag, " avg"}, 32'(bus.AverageScore), expAvg);
    check({tag, " empty"}, 32'(bus.Empty), (expCnt == 0) ? 1 : 0);
    check({tag, " busy low"}, 32'(bus.Busy), 0);
    check({tag, " index"}, 32'(bus.DisplayIndex), lastIdx);
    check({tag, " value"}, 32'(bus.DisplayValue), 32'(regs[lastIdx]));
  endtask

  task automatic stepNext(input string tag);
    @(negedge Clock);
    bus.next = 1'b1;
    @(negedge Clock);
    bus.next = 1'b0;
    if (lastCnt != 0) lastIdx = (lastIdx == lastCnt) ? 1 : lastIdx + 1;
    check({tag, " step index"}, 32'(bus.DisplayIndex), lastIdx);
    check({tag, " step value"}, 32'(bus.DisplayValue), 32'(regs[lastIdx]));
    check({tag, " step valid"}, 32'(bus.Valid), 1);
  endtask

  task automatic loadVec(input vec_t v);
    for (int i = 0; i < 8; i++) regs[i] = v.r[i];
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, " addr"}, 32'(bus.ReadAddress), 0);
    check({tag, " busy"}, 32'(bus.Busy), 0);
    check({tag, " valid"}, 32'(bus.Valid), 0);
    check({tag, " empty"}, 32'(bus.Empty), 0);
    check({tag, " best"}, 32'(bus.BestScore), 0);
    check({tag, " avg"}, 32'(bus.AverageScore), 0);
    check({tag, " value"}, 32'(bus.DisplayValue), 0);
    check({tag, " index"}, 32'(bus.DisplayIndex), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int cnt, best, avg, steps;

    vecs[0] = mkVec(4, 100, 200, 150, 250, 0, 4, 100, 175, 20);
    vecs[1] = mkVec(3, 10, 20, 31, 0, 0, 3, 10, 20, 19);
    vecs[2] = mkVec(0, 55, 66, 0, 0, 0, 0, 0, 0, 1);
    vecs[3] = mkVec(7, 5, 9, 13, 2, 1000, 4, 2, 7, 20);
    vecs[4] = mkVec(8, 8191, 8191, 8191, 8191, 7, 4, 8191, 8191, 20);
    vecs[5] = mkVec(1, 0, 9, 9, 9, 9, 1, 0, 0, 17);
    vecs[6] = mkVec(2, 7, 4, 0, 0, 0, 2, 4, 5, 18);

    for (int i = 0; i < 8; i++) regs[i] = '0;
    bus.start = 1'b0;
    bus.next  = 1'b0;
    Reset     = 1'b1;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    checkAllZero("reset");

    for (int i = 0; i < 7; i++) begin
      loadVec(vecs[i]);
      runCompute($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].best, vecs[i].avg,
                 vecs[i].lat, 1'b0);
    end

    // Display stepping with wrap, then start+next together.
    loadVec(vecs[0]);
    runCompute("step", 4, 100, 175, 20, 1'b0);
    for (int i = 0; i < 4; i++) stepNext("step");
    runCompute("startnext", 4, 100, 175, 20, 1'b1);

    // next is ignored when empty.
    loadVec(vecs[2]);
    runCompute("empty", 0, 0, 0, 1, 1'b0);
    for (int i = 0; i < 3; i++) stepNext("empty");
    check("empty still", 32'(bus.Empty), 1);

    // Reset in the middle of the divide phase.
    loadVec(vecs[0]);
    @(negedge Clock);
    bus.start = 1'b1;
    @(negedge Clock);
    bus.start = 1'b0;
    repeat (8) @(negedge Clock);
    check("middiv busy", 32'(bus.Busy), 1);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    checkAllZero("middiv reset");
    @(negedge Clock);
    checkAllZero("middiv idle");
    lastBest = 0; lastAvg = 0; lastIdx = 0; lastCnt = 0;
    runCompute("after reset", 4, 100, 175, 20, 1'b0);

    // Randomized runs against the model.
    for (int t = 0; t < 25; t++) begin
      regs[0] = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 8191))
                                            : WIDTH'($urandom_range(0, 9));
      for (int i = 1; i < 8; i++) regs[i] = WIDTH'($urandom_range(0, 8191));
      model(cnt, best, avg);
      runCompute($sformatf("rand%0d", t), cnt, best, avg, (cnt == 0) ? 1 : cnt + 16,
                 1'($urandom_range(0, 1)));
      steps = $urandom_range(0, 6);
      for (int s = 0; s < steps; s++) stepNext($sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
